// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a SPRITE_W x SPRITE_H sprite from ROM into a 640-wide 8bpp frame buffer
// with transparency and screen-edge clipping, or fills the whole buffer with one colour.
module sprite_blitter #(
    parameter int          SPRITE_W = 64,
    parameter int          SPRITE_H = 64,
    parameter int          SCREEN_W = 640,
    parameter int          SCREEN_H = 480,
    parameter logic [7:0]  TRANSP   = 8'hE3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        cmd_clear,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic [15:0] rom_base,
    input  logic [7:0]  clear_color,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [18:0] frame_wrAddress,
    output logic [7:0]  frame_input,
    output logic        frame_we,
    output logic        busy,
    output logic        done
);

    localparam int               SXW        = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int               SYW        = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [SXW-1:0]   SX_LAST    = SXW'(SPRITE_W - 1);
    localparam logic [15:0]      LIN_PENULT = 16'(SPRITE_W * SPRITE_H - 2);
    localparam logic [18:0]      CLR_LAST   = 19'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [2:0] {IDLE, BLIT, DRAIN, CLEAR, DONE} state_t;
    state_t state, state_nx;

    logic [10:0]    px, py;
    logic [15:0]    base;
    logic [7:0]     color;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic [15:0]    lin;
    logic [18:0]    clr_cnt;

    // (sx, sy) is the pixel whose address is on rom_addr, so it lines up with rom_data
    logic [10:0] scr_x, scr_y;
    logic        pix_ok;
    logic [18:0] pix_addr;

    assign scr_x    = px + 11'(sx);
    assign scr_y    = py + 11'(sy);
    assign pix_ok   = !scr_x[10] && (scr_x < 11'(SCREEN_W)) &&
                      !scr_y[10] && (scr_y < 11'(SCREEN_H)) &&
                      (rom_data != TRANSP);
    assign pix_addr = ({8'd0, scr_y} << 9) + ({8'd0, scr_y} << 7) + {8'd0, scr_x};

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = cmd_clear ? CLEAR : BLIT;
            BLIT:    if (lin == LIN_PENULT) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            CLEAR:   if (clr_cnt == CLR_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr        <= '0;
            frame_wrAddress <= '0;
            frame_input     <= '0;
            frame_we        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            px              <= '0;
            py              <= '0;
            base            <= '0;
            color           <= '0;
            sx              <= '0;
            sy              <= '0;
            lin             <= '0;
            clr_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    frame_we <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        px       <= pos_x;
                        py       <= pos_y;
                        base     <= rom_base;
                        color    <= clear_color;
                        sx       <= '0;
                        sy       <= '0;
                        lin      <= '0;
                        rom_addr <= rom_base;
                        // A clear writes address 0 on the accepting edge itself
                        if (cmd_clear) begin
                            frame_we        <= 1'b1;
                            frame_wrAddress <= '0;
                            frame_input     <= clear_color;
                            clr_cnt         <= 19'd1;
                        end
                    end
                end
                BLIT: begin
                    frame_we        <= pix_ok;
                    frame_wrAddress <= pix_addr;
                    frame_input     <= rom_data;
                    if (sx == SX_LAST) begin
                        sx <= '0;
                        sy <= sy + SYW'(1);
                    end else begin
                        sx <= sx + SXW'(1);
                    end
                    lin      <= lin + 16'd1;
                    rom_addr <= base + lin + 16'd1;
                end
                DRAIN: begin
                    frame_we        <= pix_ok;
                    frame_wrAddress <= pix_addr;
                    frame_input     <= rom_data;
                end
                CLEAR: begin
                    frame_we        <= 1'b1;
                    frame_wrAddress <= clr_cnt;
                    frame_input     <= color;
                    clr_cnt         <= clr_cnt + 19'd1;
                end
                DONE: begin
                    frame_we <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    frame_we <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized bench for sprite_blitter; a short screen (64 rows) keeps the clear run small.
module tb_sprite_blitter;

    localparam int         SW = 640;
    localparam int         SH = 64;
    localparam int         W  = 64;
    localparam int         H  = 64;
    localparam int         N  = W * H;
    localparam logic [7:0] TR = 8'hE3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        cmd_clear = 1'b0;
    logic [10:0] pos_x = '0;
    logic [10:0] pos_y = '0;
    logic [15:0] rom_base = '0;
    logic [7:0]  clear_color = '0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] frame_wrAddress;
    logic [7:0]  frame_input;
    logic        frame_we, busy, done;

    logic [7:0] rom [0:65535];
    assign rom_data = rom[rom_addr];

    sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .SCREEN_W(SW), .SCREEN_H(SH), .TRANSP(TR)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .cmd_clear(cmd_clear),
        .pos_x(pos_x), .pos_y(pos_y), .rom_base(rom_base), .clear_color(clear_color),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .frame_wrAddress(frame_wrAddress), .frame_input(frame_input), .frame_we(frame_we),
        .busy(busy), .done(done)
    );

    always #10 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int exp_a[$], exp_d[$], got_a[$], got_d[$];
    int n_done, done_cyc, first_cyc, last_cyc, rst_cyc;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0: address bytes with the transparent code replaced, 1: all transparent, 2: random
    task automatic fill_rom(input int mode);
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] b;
            b = 8'(i);
            if (mode == 0) rom[i] = (b == TR) ? 8'h00 : b;
            else if (mode == 1) rom[i] = TR;
            else rom[i] = ($urandom_range(0, 7) == 0) ? TR : 8'($urandom);
        end
    endtask

    task automatic model_blit(input int x, input int y, input int base);
        exp_a.delete(); exp_d.delete();
        for (int py = 0; py < H; py++)
            for (int px = 0; px < W; px++) begin
                int xx, yy, d;
                xx = x + px;
                yy = y + py;
                d  = rom[(base + py * W + px) & 16'hFFFF];
                if (xx >= 0 && xx < SW && yy >= 0 && yy < SH && d != TR) begin
                    exp_a.push_back(yy * 640 + xx);
                    exp_d.push_back(d);
                end
            end
    endtask

    task automatic model_clear(input int c);
        exp_a.delete(); exp_d.delete();
        for (int a = 0; a < SW * SH; a++) begin
            exp_a.push_back(a);
            exp_d.push_back(c);
        end
    endtask

    task automatic run_cmd(input bit clr, input int x, input int y, input int base, input int col,
                           input int pulse_at, input int rst_at);
        int budget, busy_gap;
        got_a.delete(); got_d.delete();
        n_done = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1; rst_cyc = -1; busy_gap = 0;
        @(negedge Clk);
        start = 1'b1; cmd_clear = clr;
        pos_x = 11'(x); pos_y = 11'(y); rom_base = 16'(base); clear_color = 8'(col);
        @(posedge Clk);
        #1;
        start = 1'b0;
        pos_x = 11'($urandom); pos_y = 11'($urandom);
        rom_base = 16'($urandom); clear_color = 8'($urandom); cmd_clear = 1'($urandom);
        budget = clr ? SW * SH + 8 : N + 8;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) chk("busy_rise", busy, 1);
            if (frame_we) begin
                got_a.push_back(frame_wrAddress);
                got_d.push_back(frame_input);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("busy_at_done", busy, 0);
                end
            end
            if (cyc > 1 && done_cyc < 0 && rst_cyc < 0 && busy !== 1'b1) busy_gap++;
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                chk("rst_we", frame_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_outs", |{rom_addr, frame_wrAddress, frame_input}, 0);
                Reset = 1'b0;
            end
            if (rst_at >= 0 && rst_cyc < 0 && got_a.size() == rst_at) begin
                Reset = 1'b1;
                rst_cyc = cyc;
            end
            if (cyc == pulse_at) begin
                start = 1'b1; cmd_clear = 1'b1; pos_x = '0; pos_y = '0; rom_base = 16'($urandom);
            end else if (cyc == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (rst_cyc >= 0 && cyc >= rst_cyc + 30) break;
        end
        if (rst_at < 0) chk("busy_hold", busy_gap, 0);
    endtask

    task automatic cmp_writes(input string tag, input int upto);
        int n, fb;
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        if (upto >= 0 && upto < n) n = upto;
        if (upto < 0) chk({tag, "_count"}, got_a.size(), exp_a.size());
        fb = -1;
        for (int i = 0; i < n; i++)
            if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) begin
                fb = i;
                break;
            end
        chk({tag, "_first_bad_idx"}, fb, -1);
        if (fb >= 0) begin
            chk({tag, "_addr"}, got_a[fb], exp_a[fb]);
            chk({tag, "_data"}, got_d[fb], exp_d[fb]);
        end
    endtask

    initial begin
        int maxa, x, y, b;

        // reset held with start high
        Reset = 1'b1; start = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            chk("reset_outs", |{rom_addr, frame_wrAddress, frame_input, frame_we, busy, done}, 0);
        end
        Reset = 1'b0; start = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("idle_busy", busy, 0);
            chk("idle_we", frame_we, 0);
        end

        // full on-screen blit
        fill_rom(0);
        model_blit(0, 0, 0);
        run_cmd(0, 0, 0, 0, 0, -1, -1);
        cmp_writes("full", -1);
        chk("full_n", got_a.size(), 4096);
        if (got_a.size() > 0) begin
            chk("full_first_a", got_a[0], 0);
            chk("full_first_d", got_d[0], 0);
            chk("full_last_a", got_a[$], 40383);
        end
        chk("full_first_cyc", first_cyc, 2);
        chk("full_last_cyc", last_cyc, 1 + N);
        chk("full_done", done_cyc, 4098);
        chk("full_ndone", n_done, 1);

        // transparency: one opaque pixel at (5,3)
        fill_rom(1);
        rom[3 * W + 5] = 8'h42;
        model_blit(100, 50, 0);
        run_cmd(0, 100, 50, 0, 0, -1, -1);
        cmp_writes("transp", -1);
        chk("transp_n", got_a.size(), 1);
        if (got_a.size() > 0) begin
            chk("transp_a", got_a[0], 34025);
            chk("transp_d", got_d[0], 8'h42);
        end
        chk("transp_done", done_cyc, 4098);

        // clipping at left and bottom edges
        fill_rom(0);
        model_blit(-10, SH - 10, 0);
        run_cmd(0, -10, SH - 10, 0, 0, -1, -1);
        cmp_writes("clip", -1);
        chk("clip_n", got_a.size(), 540);
        if (got_a.size() > 0) chk("clip_first_a", got_a[0], (SH - 10) * 640);
        maxa = 0;
        foreach (got_a[i]) if (got_a[i] > maxa) maxa = got_a[i];
        chk("clip_max_ok", maxa < SW * SH, 1);
        chk("clip_done", done_cyc, 4098);

        // random positions, ROM contents and bases
        for (int k = 0; k < 3; k++) begin
            fill_rom(2);
            x = int'($urandom_range(0, 740)) - 70;
            y = int'($urandom_range(0, 140)) - 70;
            b = int'($urandom_range(0, 65535));
            model_blit(x, y, b);
            run_cmd(0, x, y, b, 0, -1, -1);
            cmp_writes("rand", -1);
            chk("rand_done", done_cyc, 4098);
            chk("rand_ndone", n_done, 1);
        end

        // clear
        model_clear(8'h1C);
        run_cmd(1, 0, 0, 0, 8'h1C, -1, -1);
        cmp_writes("clear", -1);
        chk("clear_first_cyc", first_cyc, 1);
        chk("clear_last_cyc", last_cyc, SW * SH);
        chk("clear_done", done_cyc, SW * SH + 1);
        chk("clear_ndone", n_done, 1);

        // start while busy is ignored, then reset at write 1000
        fill_rom(2);
        b = int'($urandom_range(0, 65535));
        model_blit(20, 0, b);
        run_cmd(0, 20, 0, b, 0, 100, 1000);
        cmp_writes("busyrst", 1000);
        chk("busyrst_hit", rst_cyc >= 0, 1);
        chk("busyrst_nwr", got_a.size(), 1000);
        chk("busyrst_ndone", n_done, 0);

        // recovers after the mid-command reset
        fill_rom(2);
        model_blit(300, 10, 1234);
        run_cmd(0, 300, 10, 1234, 0, -1, -1);
        cmp_writes("after", -1);
        chk("after_done", done_cyc, 4098);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
